fetch_redirect_unit: RTL and testbench
======================================

// Module: fetch_redirect_unit
// PURPOSE
//  Fetch stage that consumes select_pc/flush/stall from the control hazard unit.
//  Owns the PC register and drives a synchronous instruction memory (1-cycle read latency).
//  Presents {instr_D, pc_D, valid_D} to decode: squashes wrong-path words on a taken
//  branch and freezes on stall with no instruction lost or duplicated.
// PARAMETERS
//  ADDR_W    32   PC / memory address width
//  INSTR_W   32   instruction word width
//  RESET_PC  0    first fetch address after reset
//  PC_INC    4    sequential PC increment (mod 2^ADDR_W)
// PORTS
//  clk            in   1        rising-edge clock
//  rst_n          in   1        asynchronous active-low reset
//  select_pc      in   1        redirect to branch_target (from hazard unit)
//  flush          in   1        squash younger fetched word (asserted with select_pc)
//  stall          in   1        freeze fetch and decode-facing outputs
//  branch_target  in   ADDR_W   redirect address, valid when select_pc=1
//  imem_en        out  1        read request this cycle
//  imem_addr      out  ADDR_W   read address (=pc_F)
//  imem_rdata     in   INSTR_W  data for the address requested in the previous cycle
//  instr_D        out  INSTR_W  instruction to decode
//  pc_D           out  ADDR_W   address of instr_D
//  valid_D        out  1        instr_D is a real, correct-path instruction
// BEHAVIOUR
//  Reset (async assert, sync deassert via clk): pc_F=RESET_PC, state=BOOT, imem_en=0,
//   instr_D=0, pc_D=0, valid_D=0, skid register empty. Reset mid-operation discards all.
//  FSM states: BOOT, RUN, SQUASH.
//   BOOT: 1 cycle after reset release; imem_en=1, addr=RESET_PC; -> RUN; pc_F+=PC_INC.
//   RUN: normal fetch. select_pc -> SQUASH; else stay.
//   SQUASH: word returning this cycle is wrong-path; valid_D=0 for it; -> RUN
//    (or stay SQUASH if select_pc asserted again).
//  Next-PC priority (per cycle): select_pc > stall > sequential.
//   select_pc=1: pc_F<=branch_target, imem_en=1 for the current pc_F is ignored (squashed).
//   stall=1, select_pc=0: pc_F holds, imem_en=0, instr_D/pc_D/valid_D hold.
//   else: pc_F<=pc_F+PC_INC (wraps mod 2^ADDR_W), imem_en=1.
//  Latency: address issued in cycle T appears on instr_D/pc_D with valid_D=1 in T+1.
//  Stall with a word in flight: returning imem_rdata captured in a 1-entry skid
//   register; it is presented first when stall drops, then fetch resumes at pc_F.
//   Skid never overflows: imem_en=0 while skid is full.
//  flush=1 alone (select_pc=0): valid_D forced 0 next cycle; PC unaffected.
//  select_pc during stall: redirect wins; skid cleared; valid_D=0 next cycle.
//  branch_target must be PC_INC-aligned; misalignment is not checked.
//  valid_D=0 words: instr_D/pc_D values don't-care, but held stable during stall.
// TESTING
//  1 Reset release, no stall/branch -> imem_addr 0,4,8,C; valid_D=1 with pc_D 0,4,8 from
//    cycle 2 on; no gaps.
//  2 At pc_F=0x10 assert select_pc+flush, target 0x40, 1 cycle -> word 0x10 valid_D=0;
//    next valid pc_D=0x40, then 0x44.
//  3 Stall 3 cycles while word 0x08 in flight -> pc_D=0x04 held, imem_en=0; after release
//    pc_D=0x08 then 0x0C; no duplicate, no loss.
//  4 select_pc+stall same cycle, target 0x100 -> stall ignored; pc_F=0x100 next cycle;
//    skid cleared; first valid pc_D=0x100.
//  5 RESET_PC=0xFFFFFFFC, run 2 fetches -> imem_addr 0xFFFFFFFC then 0x00000000.
//  6 rst_n low mid-stall with skid full -> all outputs to reset values immediately;
//    after release fetch restarts at RESET_PC, old skid word never presented.

Source files
------------

// File: rtl/fetch_redirect_unit.sv
// Fetch stage: owns pc_F, drives a 1-cycle-latency instruction memory, and presents
// {instr_D, pc_D, valid_D} to decode with branch squash and stall skid buffering.
module fetch_redirect_unit #(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       INSTR_W  = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int unsigned       PC_INC   = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               select_pc,
   input  logic               flush,
   input  logic               stall,
   input  logic [ADDR_W-1:0]  branch_target,
   output logic               imem_en,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instr_D,
   output logic [ADDR_W-1:0]  pc_D,
   output logic               valid_D
);

   localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(PC_INC);

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_SQUASH = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;

   // Bookkeeping for the word returning from memory this cycle
   logic                req_q;
   logic [ADDR_W-1:0]   req_pc_q;
   logic                flush_q;

   // One-entry skid buffer for a word that returns while decode is stalled
   logic                skid_full_q;
   logic [INSTR_W-1:0]  skid_instr_q;
   logic [ADDR_W-1:0]   skid_pc_q;

   // Last values shown to decode, replayed while stalled
   logic [INSTR_W-1:0]  hold_instr_q;
   logic [ADDR_W-1:0]   hold_pc_q;
   logic                hold_valid_q;

   logic                kill;
   logic                arrive;

   // Returning word is wrong-path after a redirect or a standalone flush
   assign kill      = (state_q == ST_SQUASH) | flush_q;
   assign arrive    = req_q & ~kill;
   assign imem_addr = pc_q;

   // State register and PC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // Next state, next PC and read request; redirect beats stall beats sequential
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      imem_en = 1'b0;
      unique case (state_q)
         ST_BOOT: begin
            imem_en = 1'b1;
            state_d = ST_RUN;
            pc_d    = pc_q + PC_STEP;
         end
         ST_RUN, ST_SQUASH: begin
            // Never request while the skid holds a word, so it cannot overflow
            imem_en = select_pc | (~stall & ~skid_full_q);
            if (select_pc) begin
               state_d = ST_SQUASH;
               pc_d    = branch_target;
            end else begin
               state_d = ST_RUN;
               if (imem_en) begin
                  pc_d = pc_q + PC_STEP;
               end
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
      // BOOT is also the reset state; no request goes out until reset is released
      imem_en = imem_en & rst_n;
   end

   // Track which address (if any) returns next cycle and whether it is squashed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q    <= 1'b0;
         req_pc_q <= '0;
         flush_q  <= 1'b0;
      end else begin
         req_q    <= imem_en;
         req_pc_q <= pc_q;
         flush_q  <= flush;
      end
   end

   // Skid capture during stall; drained on stall release, dropped on redirect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_full_q  <= 1'b0;
         skid_instr_q <= '0;
         skid_pc_q    <= '0;
      end else if (stall && !select_pc) begin
         if (!skid_full_q && arrive) begin
            skid_full_q  <= 1'b1;
            skid_instr_q <= imem_rdata;
            skid_pc_q    <= req_pc_q;
         end
      end else begin
         skid_full_q <= 1'b0;
      end
   end

   // Decode-facing mux: hold while stalled, else skid first, then fresh memory data
   always_comb begin
      instr_D = hold_instr_q;
      pc_D    = hold_pc_q;
      valid_D = hold_valid_q;
      if (!stall) begin
         if (skid_full_q) begin
            instr_D = skid_instr_q;
            pc_D    = skid_pc_q;
            valid_D = ~kill;
         end else if (req_q) begin
            instr_D = imem_rdata;
            pc_D    = req_pc_q;
            valid_D = ~kill;
         end else begin
            valid_D = 1'b0;
         end
      end
   end

   // Remember what decode saw this cycle so a stall can replay it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_instr_q <= '0;
         hold_pc_q    <= '0;
         hold_valid_q <= 1'b0;
      end else begin
         hold_instr_q <= instr_D;
         hold_pc_q    <= pc_D;
         hold_valid_q <= valid_D;
      end
   end

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Self-checking bench for fetch_redirect_unit: directed scenarios plus random
// stall/redirect traffic checked against an instruction-stream reference model.
module tb_fetch_redirect_unit;

   localparam logic [31:0] HI_PC = 32'hFFFF_FFFC;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        select_pc = 1'b0;
   logic        flush = 1'b0;
   logic        stall = 1'b0;
   logic [31:0] branch_target = '0;
   logic        imem_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] instr_D;
   logic [31:0] pc_D;
   logic        valid_D;

   logic        hi_en;
   logic [31:0] hi_addr;
   logic [31:0] hi_rdata;
   logic [31:0] hi_instr;
   logic [31:0] hi_pc;
   logic        hi_valid;

   fetch_redirect_unit u_dut (
      .clk(clk), .rst_n(rst_n), .select_pc(select_pc), .flush(flush), .stall(stall),
      .branch_target(branch_target), .imem_en(imem_en), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .instr_D(instr_D), .pc_D(pc_D), .valid_D(valid_D)
   );

   fetch_redirect_unit #(.RESET_PC(HI_PC)) u_hi (
      .clk(clk), .rst_n(rst_n), .select_pc(1'b0), .flush(1'b0), .stall(1'b0),
      .branch_target(32'h0), .imem_en(hi_en), .imem_addr(hi_addr),
      .imem_rdata(hi_rdata), .instr_D(hi_instr), .pc_D(hi_pc), .valid_D(hi_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return a ^ 32'hC001_D00D;
   endfunction

   // Synchronous memories: data for the enabled address next cycle, garbage otherwise
   always @(posedge clk) begin
      imem_rdata <= imem_en ? word_of(imem_addr) : $urandom;
      hi_rdata   <= hi_en ? word_of(hi_addr) : $urandom;
   end

   int total = 0;
   int bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Reference model: expected next decode address and next fetch address
   bit          model_on;
   logic [31:0] exp_pc;
   logic [31:0] fa;
   bit          prev_ok;
   bit          prev_sel;
   logic [31:0] p_instr;
   logic [31:0] p_pc;
   logic        p_valid;
   int          gap;

   // Observed values of the last cycle, for directed checks
   logic        o_en;
   logic [31:0] o_addr;
   logic        o_valid;
   logic [31:0] o_pc;
   logic [31:0] o_instr;
   logic [31:0] h_addr;
   logic [31:0] h_pc;
   logic        h_valid;

   task automatic model_reset(input logic [31:0] rpc);
      model_on = 1'b1;
      exp_pc   = rpc;
      fa       = rpc;
      prev_ok  = 1'b0;
      prev_sel = 1'b0;
      gap      = 0;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      stall     = 1'b0;
      select_pc = 1'b0;
      flush     = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("rst_en", 32'(imem_en), 32'd0);
      check_eq("rst_valid", 32'(valid_D), 32'd0);
      check_eq("rst_pc", pc_D, 32'd0);
      rst_n = 1'b1;
      model_reset(32'h0);
   endtask

   // One clock: drive at negedge, sample mid low-phase, run the model, wait next negedge
   task automatic cycle(input bit st, input bit sel, input bit fl, input logic [31:0] tgt);
      stall         = st;
      select_pc     = sel;
      flush         = fl;
      branch_target = tgt;
      #2;
      o_en    = imem_en;
      o_addr  = imem_addr;
      o_valid = valid_D;
      o_pc    = pc_D;
      o_instr = instr_D;
      h_addr  = hi_addr;
      h_pc    = hi_pc;
      h_valid = hi_valid;
      if (model_on) begin
         if (o_en) check_eq("fetch_addr", o_addr, fa);
         if (st) begin
            if (prev_ok) begin
               check_eq("hold_valid", 32'(o_valid), 32'(p_valid));
               check_eq("hold_pc", o_pc, p_pc);
               check_eq("hold_instr", o_instr, p_instr);
            end
            if (!sel) check_eq("stall_en", 32'(o_en), 32'd0);
         end else begin
            if (prev_sel) check_eq("squash_valid", 32'(o_valid), 32'd0);
            if (o_valid) begin
               check_eq("stream_pc", o_pc, exp_pc);
               check_eq("stream_instr", o_instr, word_of(o_pc));
               exp_pc = exp_pc + 32'd4;
               gap    = 0;
            end else begin
               gap++;
               check_eq("gap_bound", 32'(gap <= 3), 32'd1);
            end
         end
         if (sel) begin
            exp_pc = tgt;
            fa     = tgt;
            gap    = 0;
         end else if (o_en) begin
            fa = fa + 32'd4;
         end
         prev_sel = sel;
         prev_ok  = 1'b1;
         p_valid  = o_valid;
         p_pc     = o_pc;
         p_instr  = o_instr;
      end
      @(negedge clk);
   endtask

   initial begin
      bit          found;
      bit          st;
      bit          sel;
      logic [31:0] tgt;

      model_on = 1'b0;

      // Sequential fetch after reset, plus wrap from the high reset address
      do_reset();
      cycle(0, 0, 0, 0);
      check_eq("t1_boot_en", 32'(o_en), 32'd1);
      check_eq("t1_addr0", o_addr, 32'h0);
      check_eq("t1_boot_valid", 32'(o_valid), 32'd0);
      check_eq("t5_addr0", h_addr, HI_PC);
      cycle(0, 0, 0, 0);
      check_eq("t1_addr1", o_addr, 32'h4);
      check_eq("t1_pc0", o_pc, 32'h0);
      check_eq("t1_valid0", 32'(o_valid), 32'd1);
      check_eq("t5_addr1", h_addr, 32'h0);
      check_eq("t5_pc0", h_pc, HI_PC);
      check_eq("t5_valid0", 32'(h_valid), 32'd1);
      cycle(0, 0, 0, 0);
      check_eq("t1_addr2", o_addr, 32'h8);
      check_eq("t1_pc1", o_pc, 32'h4);
      check_eq("t5_pc1", h_pc, 32'h0);
      cycle(0, 0, 0, 0);
      check_eq("t1_addr3", o_addr, 32'hC);
      check_eq("t1_pc2", o_pc, 32'h8);

      // Taken branch at pc_F=0x10
      cycle(0, 1, 1, 32'h40);
      check_eq("t2_addr_at_branch", o_addr, 32'h10);
      cycle(0, 0, 0, 0);
      check_eq("t2_squashed", 32'(o_valid), 32'd0);
      check_eq("t2_redirect_addr", o_addr, 32'h40);
      cycle(0, 0, 0, 0);
      check_eq("t2_first_target", o_pc, 32'h40);
      check_eq("t2_first_valid", 32'(o_valid), 32'd1);
      cycle(0, 0, 0, 0);
      check_eq("t2_next_target", o_pc, 32'h44);

      // Stall with word 0x08 in flight
      do_reset();
      repeat (3) cycle(0, 0, 0, 0);
      check_eq("t3_pre_pc", o_pc, 32'h4);
      for (int i = 0; i < 3; i++) begin
         cycle(1, 0, 0, 0);
         check_eq("t3_stall_pc", o_pc, 32'h4);
         check_eq("t3_stall_en", 32'(o_en), 32'd0);
      end
      cycle(0, 0, 0, 0);
      check_eq("t3_skid_pc", o_pc, 32'h8);
      check_eq("t3_skid_valid", 32'(o_valid), 32'd1);
      found = 1'b0;
      for (int i = 0; i < 5 && !found; i++) begin
         cycle(0, 0, 0, 0);
         if (o_valid) begin
            found = 1'b1;
            check_eq("t3_after_skid", o_pc, 32'hC);
         end
      end
      check_eq("t3_resume_seen", 32'(found), 32'd1);

      // Redirect in the same cycle as stall, with the skid full
      do_reset();
      repeat (2) cycle(0, 0, 0, 0);
      cycle(1, 0, 0, 0);
      cycle(1, 1, 1, 32'h100);
      check_eq("t4_hold_pc", o_pc, 32'h0);
      cycle(0, 0, 0, 0);
      check_eq("t4_redirect_addr", o_addr, 32'h100);
      check_eq("t4_redirect_en", 32'(o_en), 32'd1);
      check_eq("t4_squash_valid", 32'(o_valid), 32'd0);
      found = 1'b0;
      for (int i = 0; i < 5 && !found; i++) begin
         cycle(0, 0, 0, 0);
         if (o_valid) begin
            found = 1'b1;
            check_eq("t4_first_valid", o_pc, 32'h100);
         end
      end
      check_eq("t4_target_seen", 32'(found), 32'd1);

      // Flush without redirect: one word dropped, PC continues
      do_reset();
      model_on = 1'b0;
      repeat (4) cycle(0, 0, 0, 0);
      cycle(0, 0, 1, 0);
      check_eq("fl_addr", o_addr, 32'h10);
      check_eq("fl_pc", o_pc, 32'hC);
      cycle(0, 0, 0, 0);
      check_eq("fl_killed", 32'(o_valid), 32'd0);
      check_eq("fl_pc_unaffected", o_addr, 32'h14);
      cycle(0, 0, 0, 0);
      check_eq("fl_next_pc", o_pc, 32'h14);
      check_eq("fl_next_valid", 32'(o_valid), 32'd1);

      // Reset asserted mid-stall with the skid full
      do_reset();
      repeat (2) cycle(0, 0, 0, 0);
      cycle(1, 0, 0, 0);
      stall = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("t6_en", 32'(imem_en), 32'd0);
      check_eq("t6_valid", 32'(valid_D), 32'd0);
      check_eq("t6_pc", pc_D, 32'd0);
      check_eq("t6_instr", instr_D, 32'd0);
      @(negedge clk);
      do_reset();
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 0);
      check_eq("t6_restart_pc", o_pc, 32'h0);
      check_eq("t6_restart_valid", 32'(o_valid), 32'd1);
      check_eq("t6_restart_instr", o_instr, word_of(32'h0));

      // Random stall/redirect traffic against the stream model
      do_reset();
      repeat (2) cycle(0, 0, 0, 0);
      for (int i = 0; i < 4000; i++) begin
         if (i == 2000) begin
            do_reset();
            repeat (2) cycle(0, 0, 0, 0);
         end
         st  = ($urandom_range(0, 3) == 0);
         sel = ($urandom_range(0, 9) == 0);
         tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
         cycle(st, sel, sel, tgt);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
